// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the digit width and a counter-width helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DIGIT_W = 4;

    // The bit counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to any BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= DIGIT_W'(5)) begin
            o_digit = i_digit + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bits_to_bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock.
// Start/busy/done handshake; overflow flags values above 10^DIGITS-1.
module bits_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                    overflow
);

    localparam int SW    = DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_bin;
    logic [SW-1:0]    r_scr;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic [SW-1:0]    r_bcd;
    logic             r_ovf_out;
    logic             r_done;
    logic             r_busy;

    logic [SW-1:0]    w_adj;
    logic [SW-1:0]    w_scr_sh;
    logic [WIDTH-1:0] w_bin_sh;
    logic             w_carry;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scr[k*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adj[k*DIGIT_W +: DIGIT_W])
        );
    end

    // Shift {adjusted digits, binary} left; the bit leaving the top digit
    // is the overflow carry.
    if (SW > 1) begin : g_sh_wide
        assign w_scr_sh = {w_adj[SW-2:0], r_bin[WIDTH-1]};
    end else begin : g_sh_narrow
        assign w_scr_sh = r_bin[WIDTH-1];
    end
    assign w_carry  = w_adj[SW-1];
    assign w_bin_sh = r_bin << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_scr     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf_out <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // busy/done are registered so they line up with the bcd update
            r_done <= (r_state == DONE);
            r_busy <= (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin <= bin;
                        r_scr <= '0;
                        r_ovf <= 1'b0;
                        r_cnt <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    r_bin <= w_bin_sh;
                    r_scr <= w_scr_sh;
                    r_ovf <= r_ovf | w_carry;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                DONE: begin
                    r_bcd     <= r_scr;
                    r_ovf_out <= r_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf_out;

endmodule

// File: tb/tb_bits_to_bcd_seq.sv
// Directed bench for bits_to_bcd_seq: three parameterisations share
// one clock and reset; expected values are hand-computed constants.
module tb_bits_to_bcd_seq;

    logic        clk;
    logic        rst;

    logic        start_a, busy_a, done_a, ovf_a;
    logic [8:0]  bin_a;
    logic [11:0] bcd_a;

    logic        start_b, busy_b, done_b, ovf_b;
    logic [8:0]  bin_b;
    logic [7:0]  bcd_b;

    logic        start_c, busy_c, done_c, ovf_c;
    logic [15:0] bin_c;
    logic [19:0] bcd_c;

    int errs;
    int checks;

    bits_to_bcd_seq #(.WIDTH(9), .DIGITS(3)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
    );

    bits_to_bcd_seq #(.WIDTH(9), .DIGITS(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
    );

    bits_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
        .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic dn(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic bz(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic [31:0] bcd_of(input int sel);
        case (sel)
            0: return {20'd0, bcd_a};
            1: return {24'd0, bcd_b};
            default: return {12'd0, bcd_c};
        endcase
    endfunction

    function automatic logic ovf_of(input int sel);
        case (sel)
            0: return ovf_a;
            1: return ovf_b;
            default: return ovf_c;
        endcase
    endfunction

    function automatic logic [11:0] ref3(input int v);
        logic [3:0] h, t, u;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic set_in(input int sel, input logic s, input logic [15:0] b);
        case (sel)
            0: begin start_a = s; bin_a = b[8:0]; end
            1: begin start_b = s; bin_b = b[8:0]; end
            default: begin start_c = s; bin_c = b; end
        endcase
    endtask

    // One full conversion: latency, busy width, result, single-cycle done.
    task automatic conv(input int sel, input logic [15:0] b,
                        input logic [31:0] exp_bcd, input logic exp_ovf,
                        input int lat, input string tag);
        int n;
        int bcnt;
        @(negedge clk);
        set_in(sel, 1'b1, b);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 16'hdead);
        n = 0;
        bcnt = 0;
        while (!dn(sel) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bz(sel)) bcnt++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " busy_cycles"}, bcnt, lat);
        chk({tag, " bcd"}, bcd_of(sel), exp_bcd);
        chk({tag, " overflow"}, ovf_of(sel), exp_ovf);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, dn(sel), 1'b0);
        chk({tag, " busy_end"}, bz(sel), 1'b0);
    endtask

    initial begin
        int d1, d2, ndone;
        logic [11:0] first_bcd;
        errs = 0;
        checks = 0;
        rst = 1'b1;
        start_a = 1'b0; bin_a = '0;
        start_b = 1'b0; bin_b = '0;
        start_c = 1'b0; bin_c = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy_a, 1'b0);
        chk("rst done", done_a, 1'b0);
        chk("rst bcd", bcd_a, 12'h000);
        chk("rst ovf", ovf_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        conv(0, 16'd0,   32'h000, 1'b0, 10, "zero");
        conv(0, 16'd511, 32'h511, 1'b0, 10, "v511");
        conv(0, 16'd255, 32'h255, 1'b0, 10, "v255");
        conv(0, 16'd100, 32'h100, 1'b0, 10, "v100");

        for (int i = 0; i < 512; i++) begin
            conv(0, 16'(i), {20'd0, ref3(i)}, 1'b0, 10, "sweep");
        end

        // start while busy is ignored; start held through DONE is taken
        // in the following IDLE cycle.
        @(negedge clk);
        start_a = 1'b1;
        bin_a = 9'd123;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        d1 = -1;
        d2 = -1;
        ndone = 0;
        first_bcd = '0;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = n;
                    first_bcd = bcd_a;
                end else if (d2 < 0) begin
                    d2 = n;
                end
            end
            if (n == 2) begin start_a = 1'b1; bin_a = 9'd456; end
            if (n == 5) start_a = 1'b0;
            if (n == 9) begin start_a = 1'b1; bin_a = 9'd77; end
            if (n == 21) start_a = 1'b0;
        end
        chk("ign first_done", d1, 10);
        chk("ign bcd", first_bcd, 12'h123);
        chk("b2b second_done", d2, 21);
        chk("b2b bcd", bcd_a, 12'h077);
        chk("b2b done_count", ndone, 2);

        // reset during the 5th SHIFT cycle abandons the conversion
        @(negedge clk);
        start_a = 1'b1;
        bin_a = 9'd300;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", busy_a, 1'b0);
        chk("abort done", done_a, 1'b0);
        chk("abort bcd", bcd_a, 12'h000);
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
        end
        chk("abort no_done", ndone, 0);
        conv(0, 16'd42, 32'h042, 1'b0, 10, "after_abort");

        conv(1, 16'd99,  32'h99, 1'b0, 10, "d2_99");
        conv(1, 16'd100, 32'h00, 1'b1, 10, "d2_100");
        conv(1, 16'd511, 32'h11, 1'b1, 10, "d2_511");
        conv(1, 16'd7,   32'h07, 1'b0, 10, "d2_7");

        conv(2, 16'd65535, 32'h65535, 1'b0, 17, "w16_max");
        conv(2, 16'd10000, 32'h10000, 1'b0, 17, "w16_10k");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/bits_to_bcd_seq.md
Name: bits_to_bcd_seq

Overview:
- Iterative (double-dabble) binary-to-BCD converter: one input bit processed per clock.
- Parametrised in input width and decimal digit count.
- Start/busy/done handshake and overflow flag.
- Sequential successor to the combinational 9-bit hundreds/tens/units converter; feeds the display/multiplexing stage of the project.

Parameters:
- WIDTH, 9, binary input width in bits (>= 1).
- DIGITS, 3, number of BCD output digits (>= 1); digit 0 = units.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  WIDTH  binary value; captured on the accepted start cycle.
- busy  out  1  high from the cycle after start acceptance through the DONE cycle inclusive.
- done  out  1  single-cycle pulse when bcd/overflow are updated.
- bcd  out  4*DIGITS  result; digit k at bits [4k+3:4k]; held until the next done.
- overflow  out  1  high if bin > 10^DIGITS - 1; updated with bcd.

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - state=IDLE; busy=0, done=0, bcd=0, overflow=0.
  - Shift register and counter are cleared.
  - Any conversion in progress is abandoned with no done pulse.
- States:
  - IDLE: busy=0.
    - start=1 -> capture bin into the shift register.
    - Clear the BCD scratch register and the overflow scratch bit.
    - Load bit counter = WIDTH; go to SHIFT.
  - SHIFT: busy=1.
    - Each cycle, step 1: for every scratch digit >= 5, add 3 (4-bit, no carry between digits).
    - Step 2: shift the {scratch digits, binary reg} concatenation left by 1.
    - Decrement the counter; when the counter reaches 1 in the current cycle, go to DONE.
  - DONE: busy=1, done=1 for exactly this cycle.
    - bcd and overflow output registers load the scratch values.
    - Next state IDLE.
- Overflow: the bit shifted out of the MSB of the top scratch digit during any SHIFT cycle sets the overflow scratch bit (sticky within the conversion).
  - With overflow=1, bcd holds the low DIGITS decimal digits of bin (value mod 10^DIGITS).
- Latency:
  - start accepted at edge T0.
  - SHIFT occupies edges T1..T_WIDTH.
  - done=1 and the new bcd are visible after edge T_(WIDTH+1).
  - Total is WIDTH+1 cycles; WIDTH=9 gives 10 cycles.
- start while busy (SHIFT or DONE) is ignored; it is neither queued nor does it corrupt the conversion.
- Back-to-back: start held high is accepted again in the IDLE cycle following DONE, so the throughput is one conversion per WIDTH+2 cycles.
- bin changes after acceptance have no effect.
- Outputs bcd/overflow change only on the DONE cycle or on reset.
- Counter width is $clog2(WIDTH+1); no wrap is possible since it is loaded each start.
- Corner case WIDTH=1: a single SHIFT cycle, then DONE.

Decomposition:
- Shared package bcd_pkg:
  - state typedef {IDLE, SHIFT, DONE}.
  - localparam DIGIT_W = 4.
  - Function for the counter width.
- One natural sub-module: bcd_digit_adj.
  - Combinational 4-bit: out = in >= 5 ? in + 3 : in.
  - Instanced DIGITS times via generate.
- FSM, shift datapath and output registers stay in bits_to_bcd_seq.

Test Plan:
- Default params, rst high 2 cycles, bin=0, start pulse -> done exactly 10 cycles after the start edge, bcd=12'h000, overflow=0; busy high 10 cycles.
- bin=511 -> bcd=12'h511; bin=255 -> 12'h255; bin=100 -> 12'h100; each with a single-cycle done.
- Exhaustive sweep 0..511, one conversion per request -> each digit equals (i/100)%10, (i/10)%10, i%10 via reference model; overflow always 0.
- bin=123 start, then start=1 with bin=456 during SHIFT cycles 3-5 -> result 12'h123, exactly one done; holding start high after DONE -> next conversion begins the cycle after IDLE entry.
- Start bin=300, assert rst at the 5th SHIFT cycle -> no done pulse, busy=0, bcd=0 next cycle; new start with bin=42 -> bcd=12'h042.
- WIDTH=9, DIGITS=2: bin=99 -> bcd=8'h99, overflow=0; bin=100 -> overflow=1, bcd=8'h00; bin=511 -> overflow=1, bcd=8'h11.
- WIDTH=16, DIGITS=5: bin=65535 -> 20'h65535, done after 17 cycles.
